tcm_dec_symb_frame_ctrl: RTL and testbench
==========================================

// Module: tcm_dec_symb_frame_ctrl
// PURPOSE
//  Frame sequencer for the 4D-8PSK TCM decoder input. Takes the raw 8PSK symbol-metric stream and
//  frames it into packets of ilen 4D symbols (4*ilen 8PSK symbols). Registers the data and drives
//  o1sps/osop/oval/oeop for the 4D symbol-metric assembler. oval marks Z0, the first symbol of
//  each 4D symbol. Sits between the metric calculator and the assembler.
// PARAMETERS
//  pLEN_W     16  width of frame length (in 4D symbols)
//  pSYMB_M_W   8  symbol metric width (sizes symb_m_t from tcm_dec_types.svh)
// PORTS
//  iclk          in   1         clock
//  ireset        in   1         synchronous reset, active high
//  iclkena       in   1         clock enable; low = all state and outputs frozen
//  istart        in   1         frame start request (pulse)
//  iabort        in   1         abort current frame (pulse)
//  ilen          in   pLEN_W    frame length in 4D symbols, sampled on accepted istart
//  i1sps         in   1         input symbol strobe
//  isymb_m       in   symb_m_t  symbol metrics
//  isymb_m_sign  in   symb_m_sign_t symbol metric signs
//  o1sps         out  1         output symbol strobe, to assembler i1sps
//  osop          out  1         first 8PSK symbol of frame
//  oval          out  1         Z0 of each 4D symbol, to assembler ival
//  oeop          out  1         last 8PSK symbol (Z3 of last 4D symbol)
//  osymb_m       out  symb_m_t  registered isymb_m
//  osymb_m_sign  out  symb_m_sign_t registered isymb_m_sign
//  obusy         out  1         frame in progress
//  odone         out  1         1-cycle pulse after oeop symbol
//  oerr          out  1         1-cycle pulse: rejected istart (busy or ilen==0)
//  odrop         out  1         1-cycle pulse: i1sps while IDLE, symbol discarded
// BEHAVIOUR
//  - Reset: state IDLE; all counters 0; o1sps, osop, oval, oeop, obusy, odone, oerr, odrop = 0.
//    osymb_m/osymb_m_sign are not reset. Reset mid-frame aborts immediately; no oeop or odone.
//  - All updates only when iclkena=1.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    IDLE: istart & ilen!=0 -> RUN, latch ilen, sub_cnt=0, blk_cnt=0.
//          istart & ilen==0 -> oerr, stay IDLE. i1sps -> odrop, o1sps stays 0.
//    RUN: each i1sps -> o1sps=1 next cycle with registered data.
//         oval=(sub_cnt==0). osop=(sub_cnt==0 & blk_cnt==0).
//         oeop=(sub_cnt==3 & blk_cnt==len-1). Then sub_cnt wraps mod 4, and blk_cnt++ on sub wrap.
//         After the oeop symbol -> DONE. istart in RUN -> oerr, ignored.
//    DONE: odone=1 for 1 cycle -> IDLE. istart in DONE -> oerr.
//  - iabort in RUN/DONE -> IDLE next cycle; no oeop/odone; the strobe in the same cycle is dropped.
//    iabort and istart in the same cycle: abort wins; istart is ignored without oerr.
//  - Latency: input strobe to o1sps/flags/data = 1 cycle. Flags are qualified by o1sps
//    (all flags are 0 when o1sps=0).
//  - obusy=1 in RUN and DONE. blk_cnt is pLEN_W bits; len=2^pLEN_W-1 is legal, no overflow.
//  - Back-to-back: istart accepted in the cycle after odone.
// CONFIGURATION
//  TCM_DEC_FRAME_CTRL_PHASE_EN defined: adds input iphase[1:0], latched with ilen.
//    The first iphase symbols of a frame are discarded as odrop; framing starts on the next
//    symbol. This resolves 4D boundary ambiguity.
//  Undefined: no iphase port; framing starts on the first symbol after start (phase 0).
// TESTING
//  1. istart, ilen=2, 8 strobes -> osop+oval on sym0, oval on sym4, oeop on sym7, odone next cycle.
//  2. ilen=0 istart -> oerr 1 cycle, obusy stays 0; 3 strobes in IDLE -> 3 odrop, o1sps=0.
//  3. iabort after sym5 of ilen=3 frame -> IDLE, no oeop/odone; new istart ilen=1 -> clean 4-sym frame.
//  4. istart during RUN and istart+iabort same cycle -> oerr only for first; abort wins.
//  5. iclkena toggled 0/1 randomly, ilen=4 -> identical flag/data sequence to iclkena=1 run.
//  6. PHASE_EN, iphase=2, ilen=1 -> 2 odrop, then oval on sym2, oeop on sym5.

Source files
------------

// File: rtl/tcm_dec_symb_frame_ctrl_if.sv
// rtl/tcm_dec_symb_frame_ctrl_if.sv - 8PSK symbol-metric stream in and framed stream out of the frame sequencer
interface tcm_dec_symb_frame_ctrl_if #(
  parameter int pSYMB_M_W = 8
) ();

  // upstream raw symbol stream from the metric calculator
  logic                 i1sps;
  logic [pSYMB_M_W-1:0] isymb_m;
  logic [2:0]           isymb_m_sign;

  // framed stream towards the 4D symbol-metric assembler
  logic                 o1sps;
  logic                 osop;
  logic                 oval;
  logic                 oeop;
  logic [pSYMB_M_W-1:0] osymb_m;
  logic [2:0]           osymb_m_sign;

  modport master (
    output i1sps, isymb_m, isymb_m_sign,
    input  o1sps, osop, oval, oeop, osymb_m, osymb_m_sign
  );

  modport slave (
    input  i1sps, isymb_m, isymb_m_sign,
    output o1sps, osop, oval, oeop, osymb_m, osymb_m_sign
  );

endinterface

// File: rtl/tcm_dec_symb_frame_ctrl.sv
// rtl/tcm_dec_symb_frame_ctrl.sv - frames 8PSK metrics into ilen 4D symbols; TCM_DEC_FRAME_CTRL_PHASE_EN adds iphase
module tcm_dec_symb_frame_ctrl #(
  parameter int pLEN_W    = 16,
  parameter int pSYMB_M_W = 8
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              istart,
  input  logic              iabort,
  input  logic [pLEN_W-1:0] ilen,
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
  input  logic [1:0]        iphase,
`endif
  tcm_dec_symb_frame_ctrl_if.slave sym,
  output logic              obusy,
  output logic              odone,
  output logic              oerr,
  output logic              odrop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [pLEN_W-1:0] len_r;
  logic [pLEN_W-1:0] blk_cnt;
  logic [1:0]        sub_cnt;
  logic              last_symb;
  logic [pSYMB_M_W-1:0] symb_m_d;
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
  logic [1:0]        ph_cnt;
`endif

  assign symb_m_d  = sym.isymb_m;
  // Z3 of the final 4D symbol; blk_cnt never needs to count past len_r
  assign last_symb = (sub_cnt == 2'd3) && (blk_cnt == len_r - 1'b1);

  // frame sequencer: state, counters, registered strobe/flags/data and status pulses
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state     <= IDLE;
      len_r     <= '0;
      blk_cnt   <= '0;
      sub_cnt   <= '0;
      obusy     <= 1'b0;
      odone     <= 1'b0;
      oerr      <= 1'b0;
      odrop     <= 1'b0;
      sym.o1sps <= 1'b0;
      sym.osop  <= 1'b0;
      sym.oval  <= 1'b0;
      sym.oeop  <= 1'b0;
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
      ph_cnt    <= '0;
`endif
    end else if (iclkena) begin
      sym.o1sps <= 1'b0;
      sym.osop  <= 1'b0;
      sym.oval  <= 1'b0;
      sym.oeop  <= 1'b0;
      odone     <= 1'b0;
      oerr      <= 1'b0;
      odrop     <= 1'b0;
      if (sym.i1sps) begin
        sym.osymb_m      <= symb_m_d;
        sym.osymb_m_sign <= sym.isymb_m_sign;
      end
      case (state)
        IDLE: begin
          if (sym.i1sps) odrop <= 1'b1;
          if (istart) begin
            if (ilen != '0) begin
              state   <= RUN;
              obusy   <= 1'b1;
              len_r   <= ilen;
              blk_cnt <= '0;
              sub_cnt <= '0;
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
              ph_cnt  <= iphase;
`endif
            end else begin
              oerr <= 1'b1;
            end
          end
        end
        RUN: begin
          if (iabort) begin
            state <= IDLE;
            obusy <= 1'b0;
          end else begin
            if (istart) oerr <= 1'b1;
            if (sym.i1sps) begin
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
              if (ph_cnt != 2'd0) begin
                odrop  <= 1'b1;
                ph_cnt <= ph_cnt - 2'd1;
              end else begin
`else
              begin
`endif
                sym.o1sps <= 1'b1;
                sym.oval  <= (sub_cnt == 2'd0);
                sym.osop  <= (sub_cnt == 2'd0) && (blk_cnt == '0);
                sym.oeop  <= last_symb;
                sub_cnt   <= sub_cnt + 2'd1;
                if (sub_cnt == 2'd3) blk_cnt <= blk_cnt + 1'b1;
                if (last_symb) state <= DONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          obusy <= 1'b0;
          if (!iabort) begin
            odone <= 1'b1;
            if (istart) oerr <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          obusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_dec_symb_frame_ctrl.sv
// tb/tb_tcm_dec_symb_frame_ctrl.sv - randomized self-checking bench for tcm_dec_symb_frame_ctrl
module tb_tcm_dec_symb_frame_ctrl;

  logic        iclk = 1'b0;
  logic        ireset, iclkena, istart, iabort;
  logic [15:0] ilen;
  logic        obusy, odone, oerr, odrop;
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
  logic [1:0]  iphase;
`endif

  tcm_dec_symb_frame_ctrl_if #(.pSYMB_M_W(8)) bus ();

  tcm_dec_symb_frame_ctrl #(.pLEN_W(16), .pSYMB_M_W(8)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .istart  (istart),
    .iabort  (iabort),
    .ilen    (ilen),
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
    .iphase  (iphase),
`endif
    .sym     (bus),
    .obusy   (obusy),
    .odone   (odone),
    .oerr    (oerr),
    .odrop   (odrop)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic       o1sps, osop, oval, oeop, obusy, odone, oerr, odrop;
    logic [7:0] m;
    logic [2:0] sg;
  } obs_t;

  obs_t obs, m_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model: frame described by symbol index k within the frame
  bit m_active, m_done;
  int m_len, m_k, m_ph;
  int cur_phase = 0;

  task automatic model_step(input logic st, ab, input logic [15:0] ln, input logic sps, en,
                            input logic [7:0] d, input logic [2:0] g);
    obs_t e;
    if (!en) return;
    e = '0;
    if (m_active) begin
      if (ab) m_active = 0;
      else begin
        if (st) e.oerr = 1'b1;
        if (sps) begin
          if (m_ph > 0) begin
            e.odrop = 1'b1;
            m_ph--;
          end else begin
            e.o1sps = 1'b1;
            e.m     = d;
            e.sg    = g;
            e.oval  = (m_k % 4 == 0);
            e.osop  = (m_k == 0);
            e.oeop  = (m_k == 4 * m_len - 1);
            m_k++;
            if (m_k == 4 * m_len) begin
              m_active = 0;
              m_done   = 1;
            end
          end
        end
      end
    end else if (m_done) begin
      m_done = 0;
      if (!ab) begin
        e.odone = 1'b1;
        if (st) e.oerr = 1'b1;
      end
    end else begin
      if (sps) e.odrop = 1'b1;
      if (st) begin
        if (ln == 16'd0) e.oerr = 1'b1;
        else begin
          m_active = 1;
          m_len    = int'(ln);
          m_k      = 0;
          m_ph     = cur_phase;
        end
      end
    end
    e.obusy = m_active || m_done;
    m_exp   = e;
  endtask

  task automatic sample_obs();
    obs.o1sps = bus.o1sps;
    obs.osop  = bus.osop;
    obs.oval  = bus.oval;
    obs.oeop  = bus.oeop;
    obs.obusy = obusy;
    obs.odone = odone;
    obs.oerr  = oerr;
    obs.odrop = odrop;
    obs.m     = bus.o1sps ? bus.osymb_m : 8'h0;
    obs.sg    = bus.o1sps ? bus.osymb_m_sign : 3'h0;
  endtask

  // drive one clock of inputs from a negedge, sample at the following negedge
  task automatic cyc(input logic st, ab, input logic [15:0] ln, input logic sps, en,
                     input logic [7:0] d, input logic [2:0] g);
    istart           = st;
    iabort           = ab;
    ilen             = ln;
    bus.i1sps        = sps;
    bus.isymb_m      = d;
    bus.isymb_m_sign = g;
    iclkena          = en;
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
    iphase           = cur_phase[1:0];
`endif
    model_step(st, ab, ln, sps, en, d, g);
    @(posedge iclk);
    @(negedge iclk);
    sample_obs();
  endtask

  task automatic rcyc(input logic st, ab, input logic [15:0] ln, input logic sps);
    cyc(st, ab, ln, sps, 1'b1, 8'($urandom), 3'($urandom));
  endtask

  task automatic apply_reset();
    ireset    = 1'b1;
    iclkena   = 1'b1;
    istart    = 1'($urandom);
    iabort    = 1'b0;
    ilen      = 16'd2;
    bus.i1sps = 1'($urandom);
    @(posedge iclk);
    @(negedge iclk);
    ireset    = 1'b0;
    istart    = 1'b0;
    bus.i1sps = 1'b0;
    m_active  = 0;
    m_done    = 0;
    m_exp     = '0;
    sample_obs();
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (obs !== 19'h0) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", obs, 19'h0);
    end
  endtask

  task automatic test_basic_frame();
    rcyc(1, 0, 16'd2, 0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) rcyc(0, 0, 16'd0, i <= 8);
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL basic_frame cyc %0d: got %h want %h", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_len_zero_drop();
    for (int i = 0; i < 6; i++) begin
      rcyc(i == 0, 0, 16'd0, i >= 1 && i <= 3);
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL len_zero_drop cyc %0d: got %h want %h", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_abort();
    // ilen=3 frame, abort after sym5, then a clean ilen=1 frame
    for (int i = 0; i < 18; i++) begin
      if (i == 0)       rcyc(1, 0, 16'd3, 0);
      else if (i <= 6)  rcyc(0, 0, 16'd0, 1);
      else if (i == 7)  rcyc(0, 1, 16'd0, 1);
      else if (i == 9)  rcyc(1, 0, 16'd1, 0);
      else              rcyc(0, 0, 16'd0, i >= 10 && i <= 13);
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL abort cyc %0d: got %h want %h", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_start_in_run();
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      rcyc(1, 0, 16'd2, 0);
      else if (i == 2) rcyc(1, 0, 16'd5, 1);
      else if (i == 4) rcyc(1, 1, 16'd5, 1);
      else             rcyc(0, 0, 16'd0, 1);
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL start_in_run cyc %0d: got %h want %h", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_clkena();
    logic       st[64], sp[64];
    logic [7:0] dd[64];
    logic [2:0] gg[64];
    obs_t       qa[$], qb[$];
    for (int i = 0; i < 64; i++) begin
      st[i] = (i == 0);
      sp[i] = (i > 0) && ((i > 40) || ($urandom_range(0, 3) != 0));
      dd[i] = 8'($urandom);
      gg[i] = 3'($urandom);
    end
    for (int i = 0; i < 64; i++) begin
      cyc(st[i], 0, 16'd4, sp[i], 1'b1, dd[i], gg[i]);
      qa.push_back(obs);
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL clkena_ref cyc %0d: got %h want %h", i, obs, m_exp);
      end
    end
    for (int i = 0; i < 64; i++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        cyc(1'($urandom), 0, 16'($urandom_range(0, 3)), 1'($urandom), 1'b0, 8'($urandom), 3'($urandom));
        n_tests++;
        if (obs !== m_exp) begin
          n_fail++;
          $display("FAIL clkena_hold cyc %0d: got %h want %h", i, obs, m_exp);
        end
      end
      cyc(st[i], 0, 16'd4, sp[i], 1'b1, dd[i], gg[i]);
      qb.push_back(obs);
    end
    for (int i = 0; i < 64; i++) begin
      n_tests++;
      if (qb[i] !== qa[i]) begin
        n_fail++;
        $display("FAIL clkena_seq idx %0d: got %h want %h", i, qb[i], qa[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int seen_done = 0;
    rcyc(1, 0, 16'd1, 0);
    for (int i = 0; i < 14; i++) begin
      // restart in the first cycle odone is visible
      if (obs.odone && seen_done == 0) begin
        seen_done = 1;
        rcyc(1, 0, 16'd1, 0);
      end else begin
        rcyc(0, 0, 16'd0, 1'($urandom_range(0, 3) != 0));
      end
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    rcyc(1, 0, 16'd2, 0);
    for (int i = 0; i < 3; i++) rcyc(0, 0, 16'd0, 1);
    apply_reset();
    n_tests++;
    if (obs !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want %h", obs, 19'h0);
    end
    for (int i = 0; i < 3; i++) begin
      rcyc(0, 0, 16'd0, 1);
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc %0d: got %h want %h", i, obs, m_exp);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      rcyc(1, 0, 16'($urandom_range(1, 4)), 0);
      for (int i = 0; i < 40; i++) begin
        rcyc($urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0, 16'($urandom_range(0, 3)),
             1'($urandom_range(0, 2) != 0));
        n_tests++;
        if (obs !== m_exp) begin
          n_fail++;
          $display("FAIL random frame %0d cyc %0d: got %h want %h", f, i, obs, m_exp);
        end
      end
      for (int i = 0; i < 3; i++) rcyc(0, 1, 16'd0, 0);
    end
  endtask

`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
  task automatic test_phase();
    cur_phase = 2;
    rcyc(1, 0, 16'd1, 0);
    for (int i = 0; i < 9; i++) begin
      rcyc(0, 0, 16'd0, i < 6);
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL phase cyc %0d: got %h want %h", i, obs, m_exp);
      end
    end
    cur_phase = 0;
  endtask
`endif

  initial begin
    ireset           = 1'b1;
    iclkena          = 1'b1;
    istart           = 1'b0;
    iabort           = 1'b0;
    ilen             = 16'd0;
    bus.i1sps        = 1'b0;
    bus.isymb_m      = 8'h0;
    bus.isymb_m_sign = 3'h0;
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
    iphase           = 2'd0;
`endif
    @(negedge iclk);
    test_reset();
    test_basic_frame();
    test_len_zero_drop();
    test_abort();
    test_start_in_run();
    test_clkena();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef TCM_DEC_FRAME_CTRL_PHASE_EN
    test_phase();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
